// File: rtl/descrambler_64b66b_rx_pkg.sv
// Shared constants, lock FSM states and header helper
// for the 64b/66b receive descrambler and block lock.
package descrambler_64b66b_rx_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int SH_CNT_MAX     = 64;
  localparam int SH_INVALID_MAX = 16;

  localparam int TAP0 = 39;
  localparam int TAP1 = 58;

  typedef enum logic [1:0] {
    RESET_CNT,
    TEST_SH,
    SLIP
  } lock_state_e;

  function automatic logic sh_valid(
    input logic [1:0] h
  );
    return (h == SYNC_DATA) ||
           (h == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/block_lock_64b66b.sv
// Sync-header block lock FSM: 64-header windows, slip on bad header.
// Ports: clk, nreset, valid_i, head_i -> lock_o, slip_o (registered).
module block_lock_64b66b
  import descrambler_64b66b_rx_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       valid_i,
  input  logic [1:0] head_i,
  output logic       lock_o,
  output logic       slip_o
);

  lock_state_e r_state;
  lock_state_e w_state_nxt;

  logic [6:0] r_sh_cnt;
  logic [6:0] w_sh_nxt;
  logic [6:0] w_sh_inc;
  logic [4:0] r_inv_cnt;
  logic [4:0] w_inv_nxt;
  logic [4:0] w_inv_inc;
  logic       r_lock;
  logic       w_lock_nxt;
  logic       r_slip;
  logic       w_bad;
  logic       w_win_end;
  logic       w_inv_max;

  assign w_bad     = !sh_valid(head_i);
  assign w_sh_inc  = r_sh_cnt + 7'd1;
  assign w_inv_inc = r_inv_cnt +
                     {4'd0, w_bad};
  assign w_win_end =
    (w_sh_inc == 7'(SH_CNT_MAX));
  assign w_inv_max =
    (w_inv_inc == 5'(SH_INVALID_MAX));

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh_cnt;
    w_inv_nxt   = r_inv_cnt;
    w_lock_nxt  = r_lock;
    unique case (r_state)
      RESET_CNT: begin
        w_sh_nxt    = '0;
        w_inv_nxt   = '0;
        w_state_nxt = TEST_SH;
      end
      TEST_SH: begin
        if (valid_i) begin
          w_sh_nxt  = w_sh_inc;
          w_inv_nxt = w_inv_inc;
          // 16th bad header beats window end
          if (w_bad && w_inv_max) begin
            w_lock_nxt  = 1'b0;
            w_state_nxt = SLIP;
          end else if (w_bad && !r_lock) begin
            w_state_nxt = SLIP;
          end else if (w_win_end) begin
            if (w_inv_inc == 5'd0)
              w_lock_nxt = 1'b1;
            w_state_nxt = RESET_CNT;
          end
        end
      end
      SLIP: begin
        w_lock_nxt  = 1'b0;
        w_state_nxt = RESET_CNT;
      end
      default: begin
        w_state_nxt = RESET_CNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= RESET_CNT;
      r_sh_cnt  <= '0;
      r_inv_cnt <= '0;
      r_lock    <= 1'b0;
      r_slip    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sh_cnt  <= w_sh_nxt;
      r_inv_cnt <= w_inv_nxt;
      r_lock    <= w_lock_nxt;
      // high exactly while in SLIP
      r_slip    <= (w_state_nxt == SLIP);
    end
  end

  assign lock_o = r_lock;
  assign slip_o = r_slip;

endmodule

// File: rtl/descrambler_64b66b_rx.sv
// 64b/66b receive path: x^58+x^39+1 self-sync descrambler + block lock.
// Ports: clk, nreset, valid_i/head_i/data_i in; valid_o/head_o/data_o, lock_o, slip_o out.
module descrambler_64b66b_rx
  import descrambler_64b66b_rx_pkg::*;
#(
  parameter int LEN = 64
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           valid_i,
  input  logic [1:0]     head_i,
  input  logic [LEN-1:0] data_i,
  output logic           valid_o,
  output logic [1:0]     head_o,
  output logic [LEN-1:0] data_o,
  output logic           lock_o,
  output logic           slip_o
);

  // r_s_q[k]: stream bit k+1 before data_i[0]
  logic [TAP1-1:0]     r_s_q;
  logic [TAP1-1:0]     w_s_nxt;
  logic [TAP1-1:0]     w_hist;
  logic [LEN+TAP1-1:0] w_ext;
  logic [LEN-1:0]      w_desc;

  logic           r_valid;
  logic [1:0]     r_head;
  logic [LEN-1:0] r_data;

  // w_hist is oldest-first so that w_ext
  // is the stream in wire order from
  // bit -58 up to bit LEN-1
  always_comb begin
    w_hist = '0;
    for (int k = 0; k < TAP1; k++)
      w_hist[TAP1-1-k] = r_s_q[k];
  end

  assign w_ext = {data_i, w_hist};

  // in[i-TAP0] is w_ext[i+TAP1-TAP0],
  // in[i-TAP1] is w_ext[i]
  always_comb begin
    w_desc = '0;
    for (int i = 0; i < LEN; i++)
      w_desc[i] = data_i[i] ^
                  w_ext[i+TAP1-TAP0] ^
                  w_ext[i];
  end

  always_comb begin
    w_s_nxt = '0;
    for (int k = 0; k < TAP1; k++)
      w_s_nxt[k] = data_i[LEN-1-k];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_s_q   <= '1;
      r_valid <= 1'b0;
      r_head  <= 2'b00;
      r_data  <= '0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_s_q  <= w_s_nxt;
        r_head <= head_i;
        r_data <= w_desc;
      end
    end
  end

  assign valid_o = r_valid;
  assign head_o  = r_head;
  assign data_o  = r_data;

  block_lock_64b66b u_lock (
    .clk     (clk),
    .nreset  (nreset),
    .valid_i (valid_i),
    .head_i  (head_i),
    .lock_o  (lock_o),
    .slip_o  (slip_o)
  );

endmodule
